// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: instruction-type codes,
// RV32M funct3 op encodings, FSM state encodings and operand-sign helpers.
package ex_mdu_pkg;

   typedef enum logic [2:0] {
      InstTypeR = 3'd0,
      InstTypeI = 3'd1,
      InstTypeS = 3'd2,
      InstTypeB = 3'd3,
      InstTypeU = 3'd4,
      InstTypeJ = 3'd5
   } inst_type_e;

   typedef enum logic [2:0] {
      OpMul    = 3'd0,
      OpMulh   = 3'd1,
      OpMulhsu = 3'd2,
      OpMulhu  = 3'd3,
      OpDiv    = 3'd4,
      OpDivu   = 3'd5,
      OpRem    = 3'd6,
      OpRemu   = 3'd7
   } mdu_op_e;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StMul  = 3'd1,
      StDiv  = 3'd2,
      StFix  = 3'd3,
      StDone = 3'd4
   } mdu_state_e;

   // MUL takes the low word only, which is identical for signed and unsigned operands.
   function automatic logic rs1_signed(input mdu_op_e op);
      return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
   endfunction

   function automatic logic rs2_signed(input mdu_op_e op);
      return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
   endfunction

   function automatic logic is_div_op(input mdu_op_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/mdu_mul_step.sv
// One shift-add multiply step: adds MUL_BITS partial products of the multiplicand to the
// upper accumulator half.
module mdu_mul_step #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned MUL_BITS = 1
) (
   input  logic [XLEN-1:0]          acc_hi_i,
   input  logic [XLEN-1:0]          mcand_i,
   input  logic [MUL_BITS-1:0]      mplier_i,
   output logic [XLEN+MUL_BITS-1:0] sum_o
);

   always_comb begin
      sum_o = {{MUL_BITS{1'b0}}, acc_hi_i};
      for (int unsigned i = 0; i < MUL_BITS; i++) begin
         if (mplier_i[i]) begin
            sum_o = sum_o + ({{MUL_BITS{1'b0}}, mcand_i} << i);
         end
      end
   end

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier, restoring divider, sign fix-up
// cycle and a result hold state with valid/ready handshake and pipeline stall request.
module ex_mdu
   import ex_mdu_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned MUL_BITS = 1
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            valid_in,
   output logic            ready_out,
   input  logic [2:0]      op_in,
   input  logic [XLEN-1:0] rs1_val_in,
   input  logic [XLEN-1:0] rs2_val_in,
   input  logic [4:0]      rd_addr_in,
   input  logic            flush_in,
   output logic            valid_out,
   input  logic            ready_in,
   output logic [XLEN-1:0] rd_val_out,
   output logic [4:0]      rd_addr_out,
   output logic            stallreq_from_ex
);

   localparam int unsigned CntW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MostNeg = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e          state_q, state_d;
   mdu_op_e             op_q, op_d;
   logic [4:0]          rd_addr_q, rd_addr_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opb_q, opb_d;
   logic                neg_res_q, neg_res_d;
   logic                neg_rem_q, neg_rem_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]     rd_val_q, rd_val_d;

   mdu_op_e             op_sel;
   logic                accept, s1, s2, div_zero, div_ovf;
   logic [XLEN-1:0]     mag1, mag2;
   logic [XLEN+MUL_BITS-1:0] mul_sum;
   logic [XLEN:0]       rem_sh, trial;
   logic                trial_ge;
   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     quo, rem;

   assign ready_out        = rst_in && (state_q == StIdle);
   assign valid_out        = (state_q == StDone);
   assign rd_val_out       = rd_val_q;
   assign rd_addr_out      = rd_addr_q;
   assign stallreq_from_ex = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix) ||
                             ((state_q == StDone) && !ready_in);

   assign accept   = valid_in && ready_out && !flush_in;
   assign op_sel   = mdu_op_e'(op_in);
   assign s1       = rs1_signed(op_sel) && rs1_val_in[XLEN-1];
   assign s2       = rs2_signed(op_sel) && rs2_val_in[XLEN-1];
   assign mag1     = s1 ? -rs1_val_in : rs1_val_in;
   assign mag2     = s2 ? -rs2_val_in : rs2_val_in;
   assign div_zero = (rs2_val_in == '0);
   assign div_ovf  = ((op_sel == OpDiv) || (op_sel == OpRem)) && (rs1_val_in == MostNeg) &&
                     (rs2_val_in == '1);

   mdu_mul_step #(
      .XLEN     (XLEN),
      .MUL_BITS (MUL_BITS)
   ) u_mul_step (
      .acc_hi_i (acc_q[2*XLEN-1:XLEN]),
      .mcand_i  (opb_q),
      .mplier_i (acc_q[MUL_BITS-1:0]),
      .sum_o    (mul_sum)
   );

   // Restoring divide: remainder in the upper half, dividend shifting out into quotient below.
   assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
   assign trial    = rem_sh - {1'b0, opb_q};
   assign trial_ge = (rem_sh >= {1'b0, opb_q});

   assign prod = neg_res_q ? -acc_q : acc_q;
   assign quo  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_addr_d = rd_addr_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      cnt_d     = cnt_q;
      rd_val_d  = rd_val_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               op_d      = op_sel;
               rd_addr_d = rd_addr_in;
               acc_d     = {{XLEN{1'b0}}, mag1};
               opb_d     = mag2;
               neg_res_d = s1 ^ s2;
               neg_rem_d = s1;
               if (!is_div_op(op_sel)) begin
                  cnt_d   = CntW'(XLEN / MUL_BITS);
                  state_d = StMul;
               end else if (div_zero) begin
                  rd_val_d = ((op_sel == OpDiv) || (op_sel == OpDivu)) ? '1 : rs1_val_in;
                  state_d  = StDone;
               end else if (div_ovf) begin
                  rd_val_d = (op_sel == OpDiv) ? rs1_val_in : '0;
                  state_d  = StDone;
               end else begin
                  cnt_d   = CntW'(XLEN);
                  state_d = StDiv;
               end
            end
         end
         StMul: begin
            acc_d = {mul_sum, acc_q[XLEN-1:MUL_BITS]};
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d = StFix;
            end
         end
         StDiv: begin
            acc_d = {trial_ge ? trial[XLEN-1:0] : rem_sh[XLEN-1:0], acc_q[XLEN-2:0], trial_ge};
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            unique case (op_q)
               OpMul:                     rd_val_d = prod[XLEN-1:0];
               OpMulh, OpMulhsu, OpMulhu: rd_val_d = prod[2*XLEN-1:XLEN];
               OpDiv, OpDivu:             rd_val_d = quo;
               default:                   rd_val_d = rem;
            endcase
            state_d = StDone;
         end
         StDone: begin
            if (ready_in) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (flush_in) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q   <= StIdle;
         op_q      <= OpMul;
         rd_addr_q <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         cnt_q     <= '0;
         rd_val_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rd_addr_q <= rd_addr_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         cnt_q     <= cnt_d;
         rd_val_q  <= rd_val_d;
      end
   end

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter XLEN, 32, operand/result width (even, >=8).
REQ-002 Parameter MUL_BITS, 1, multiplier bits retired per cycle; legal values 1, 2, 4; must divide XLEN.
REQ-003 clk_in  input  1  single clock; all state changes on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low.
REQ-005 valid_in  input  1  operation request.
REQ-006 ready_out  output  1  unit can accept; high only in IDLE.
REQ-007 op_in  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 rs1_val_in, rs2_val_in  input  XLEN  operands.
REQ-009 rd_addr_in  input  5  destination register.
REQ-010 flush_in  input  1  branch-mispredict kill.
REQ-011 valid_out  output  1  result available.
REQ-012 ready_in  input  1  downstream consumes result.
REQ-013 rd_val_out  output  XLEN  result.
REQ-014 rd_addr_out  output  5  destination of result.
REQ-015 stallreq_from_ex  output  1  pipeline stall request.

Function
REQ-016 FSM states IDLE, MUL, DIV, FIX, DONE; accept = valid_in && ready_out && !flush_in.
REQ-017 Accept latches op, rd_addr, operand magnitudes, and result sign: MULH/DIV/REM signed both; MULHSU rs1 signed only; MUL low word is sign-independent.
REQ-018 IDLE->MUL for ops 0-3; IDLE->DIV for ops 4-7; IDLE->DONE directly for special divide cases (REQ-022, REQ-023).
REQ-019 MUL: unsigned shift-add on magnitudes, MUL_BITS per cycle, exactly XLEN/MUL_BITS cycles, 2*XLEN-bit accumulator; then FIX.
REQ-020 DIV: restoring, 1 quotient bit per cycle, exactly XLEN cycles; then FIX.
REQ-021 FIX (1 cycle): two's-complement negate per sign rules (quotient sign = s1^s2, remainder sign = dividend sign); select low word (MUL), high word (MULH/HSU/HU), quotient or remainder; register into rd_val_out; then DONE.
REQ-022 Divide by zero: DIV/DIVU result all ones; REM/REMU result = rs1; valid_out one cycle after accept edge.
REQ-023 Signed overflow (rs1 = most-negative, rs2 = -1): DIV result = rs1, REM result = 0; one-cycle latency as REQ-022.
REQ-024 Normal latency, accept edge to first valid_out: XLEN/MUL_BITS+2 cycles (mul), XLEN+2 cycles (div).
REQ-025 DONE: valid_out=1; rd_val_out/rd_addr_out held stable until ready_in=1; DONE->IDLE on ready_in.
REQ-026 No new accept in cycle DONE->IDLE; next accept earliest the following cycle.
REQ-027 flush_in=1 in any state: next state IDLE, valid_out low next cycle, result discarded; flush beats valid_in in same cycle.
REQ-028 stallreq_from_ex = 1 in MUL, DIV, FIX, and DONE with ready_in=0; else 0.
REQ-029 valid_in while not ready_out is ignored (requester must hold it).

Reset
REQ-030 rst_in low: state IDLE, valid_out 0, rd_val_out 0, rd_addr_out 0, stallreq_from_ex 0, counters/accumulators 0, immediately and asynchronously, including mid-operation; ready_out 1 once released.

Structure
REQ-031 Op encodings and state encodings live in the shared defines file beside existing instruction-type codes.
REQ-032 One sub-module mdu_mul_step: combinational MUL_BITS-wide partial-product add, instantiated once.

Verification
REQ-033 XLEN=32, MUL_BITS=1: MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE, valid_out 34 cycles after accept.
REQ-034 MULH 0x80000000*0x80000000 -> 0x40000000; MUL 7*-3 -> 0xFFFFFFEB; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, 34-cycle latency.
REQ-036 DIV 5/0 -> 0xFFFFFFFF and REM 0x80000000/-1 -> 0, each valid_out 1 cycle after accept.
REQ-037 flush_in at cycle 10 of a DIV -> IDLE next cycle, no valid_out; new MUL 3*4 accepted after -> 12.
REQ-038 Hold ready_in=0 five cycles in DONE -> output stable, stallreq_from_ex=1; rst_in low mid-MUL -> all outputs 0 at once.
